multicycle_controller: RTL
==========================

# multicycle_controller

Parametrised control unit for the multicycle RV32I datapath: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port. It extends the single-cycle decoder with state sequencing, a req/ready memory handshake, optional LUI and BNE support, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register/flags of the datapath and all datapath mux selects and write strobes.

## Interface
Parameters:
- LUI_EN, 1, 1 enables U-type LUI decode; 0 makes opcode 0110111 illegal
- BNE_EN, 1, 1 enables BNE (funct3 001); 0 makes it illegal
- CNT_W, 32, width of retired-instruction counter

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- zero  in  1  ALU zero flag (current cycle)
- mem_ready  in  1  memory completes the pending access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a store
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address
- ir_write  out  1  load instruction register and old-PC register
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- illegal_instr  out  1  sticky trap flag
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, TRAP. Unlisted outputs are 0.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10. Stay until mem_ready; in the mem_ready cycle ir_write=1, pc_write=1, go DECODE.
- DECODE: a=01, b=01, imm_src=010, alu_op=00 (branch target into ALUOut). Next by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI (LUI_EN=1); anything else -> TRAP.
- MEMADR: a=10, b=01, alu_op=00, imm_src=000 (load) / 001 (store); -> MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, adr_src=1; hold until mem_ready, then MEMWB. MEMWB: result_src=01, reg_write=1; -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; hold until mem_ready, then FETCH.
- EXECR: a=10, b=00, alu_op=10; -> ALUWB. EXECI: a=10, b=01, imm_src=000, alu_op=10; -> ALUWB. ALUWB: result_src=00, reg_write=1; -> FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00; pc_write = zero for funct3 000, ~zero for funct3 001 (BNE_EN=1). Other funct3 (or 001 with BNE_EN=0) -> TRAP, pc_write=0. Otherwise -> FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1; -> ALUWB.
- LUI: a=11, b=01, imm_src=100, alu_op=00; -> ALUWB.
- TRAP: illegal_instr=1, all strobes 0; stays until rst.
- instr_count increments by 1 on each transition into FETCH from any state other than FETCH; TRAP entry does not count.

## Timing
- rst sampled high: state <= FETCH, instr_count <= 0, illegal_instr <= 0; while rst is high all outputs are forced 0 (mem_req included).
- Outputs are combinational from state; pc_write/ir_write in FETCH additionally depend on mem_ready, pc_write in BRANCH on zero.
- Handshake: mem_req, mem_write, adr_src stay stable until the mem_ready cycle; mem_ready while mem_req=0 is ignored.
- Zero-wait cycle counts: lw 5, sw 4, R/I/JAL/LUI 4, branch 3. Each wait cycle adds 1.
- rst asserted mid-access abandons the access; next cycle is FETCH with mem_req=0 until rst deasserts.

## Test plan
- Reset then mem_ready=1, opcode 0110011 -> FETCH, DECODE, EXECR, ALUWB; reg_write=1 in cycle 4 only; instr_count=1.
- lw with mem_ready low 3 cycles in MEMREAD -> mem_req/adr_src=1 held 4 cycles; reg_write with result_src=01 one cycle later; total 8 cycles.
- beq zero=1 then zero=0 -> pc_write=1 in BRANCH first case, 0 second; both return to FETCH, instr_count=2.
- bne (funct3 001) zero=0 with BNE_EN=1 -> pc_write=1; BNE_EN=0 -> TRAP, illegal_instr=1, instr_count unchanged.
- Opcode 0110111 with LUI_EN=1 -> LUI state, a=11, imm_src=100, then ALUWB; LUI_EN=0 -> TRAP held until rst.
- Preload counter near 2^CNT_W-1 (CNT_W=4, 16 R-type retires) -> instr_count wraps to 0; rst mid-MEMWRITE -> mem_write drops same cycle, FETCH next.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences one shared ALU and memory port.
// Strobes decode from state; fetch/branch strobes also see mem_ready/zero.
module multicycle_controller #(
  parameter bit LUI_EN = 1'b1,
  parameter bit BNE_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ill;

  logic w_ld, w_st, w_r, w_i, w_br, w_jal, w_lui;
  logic w_br_ok, w_br_take;

  assign w_ld  = (opcode == OP_LD);
  assign w_st  = (opcode == OP_ST);
  assign w_r   = (opcode == OP_R);
  assign w_i   = (opcode == OP_I);
  assign w_br  = (opcode == OP_BR);
  assign w_jal = (opcode == OP_JAL);
  assign w_lui = LUI_EN && (opcode == OP_LUI);

  assign w_br_ok = (funct3 == 3'b000) ||
                   (BNE_EN && (funct3 == 3'b001));
  assign w_br_take = (funct3 == 3'b000) ? zero : !zero;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          w_ld, w_st: w_next = S_MEMADR;
          w_r:        w_next = S_EXECR;
          w_i:        w_next = S_EXECI;
          w_br:       w_next = S_BRANCH;
          w_jal:      w_next = S_JAL;
          w_lui:      w_next = S_LUI;
          default:    w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = w_st ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = w_br_ok ? S_FETCH : S_TRAP;
      S_JAL:      w_next = S_ALUWB;
      S_LUI:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Retire = re-entering FETCH; the trap is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_FETCH && r_state != S_FETCH)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_next == S_TRAP)
        r_ill <= 1'b1;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 3'b000;
    result_src = 2'b00;
    alu_op     = 2'b00;
    if (!rst) begin
      unique case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = 3'b010;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = w_st ? 3'b001 : 3'b000;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB:  reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = w_br_ok && w_br_take;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_LUI: begin
          alu_src_a = 2'b11;
          alu_src_b = 2'b01;
          imm_src   = 3'b100;
        end
        default: ;
      endcase
    end
  end

  assign illegal_instr = r_ill && !rst;
  assign instr_count   = rst ? '0 : r_cnt;

endmodule
